lifo_stack: RTL

Parametrised LIFO stack, the successor to the core's fixed single-port stack. It stores up to `StackDepth` words of `DataWidth` bits and supports push, pop and a combined push+pop that replaces the top entry. It exposes occupancy, full/empty status and a second read port that can look at any entry below the top. The core uses it for nested-interrupt context (return addresses, priority levels), where the replace operation serves a tail-chained handler swap without a pop/push round trip.

---
 rtl/stack_pkg.sv | 20 ++
 rtl/lifo_stack_mem.sv | 26 ++
 rtl/lifo_stack.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - operation decode and error types shared by the LIFO stack
package stack_pkg;

  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } stack_err_t;

  function automatic stack_op_t decode_op(input logic push, input logic pop);
    return stack_op_t'({push, pop});
  endfunction

endpackage

// File: rtl/lifo_stack_mem.sv
// rtl/lifo_stack_mem.sv - unreset register array, one write port, async top and peek reads
module lifo_stack_mem #(
  parameter int StackDepth = 8,
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = $clog2(StackDepth)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [DataWidth-1:0] wdata,
  input  logic [AddrWidth-1:0] top_addr,
  output logic [DataWidth-1:0] top_data,
  input  logic [AddrWidth-1:0] peek_addr,
  output logic [DataWidth-1:0] peek_data
);

  logic [DataWidth-1:0] mem [StackDepth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign top_data  = mem[top_addr];
  assign peek_data = mem[peek_addr];

endmodule

// File: rtl/lifo_stack.sv
// rtl/lifo_stack.sv - parametrised LIFO with replace and peek port
// Sticky overflow/underflow flags are built only when LIFO_STACK_ERR_EN is defined.
module lifo_stack
  import stack_pkg::*;
#(
  parameter int StackDepth = 8,
  parameter int DataWidth  = 32,
  localparam int CountWidth = $clog2(StackDepth + 1),
  localparam int PeekWidth  = $clog2(StackDepth)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DataWidth-1:0]  data_in,
  output logic [DataWidth-1:0]  data_out,
  input  logic [PeekWidth-1:0]  peek_depth,
  output logic [DataWidth-1:0]  peek_data,
  output logic [CountWidth-1:0] count,
  output logic                  full,
  output logic                  empty,
  input  logic                  err_clear,
  output logic                  overflow,
  output logic                  underflow
);

  logic                  run_q;
  stack_op_t             op;
  logic [CountWidth-1:0] count_nxt;
  logic                  we;
  logic [PeekWidth-1:0]  waddr;
  logic                  ovf_evt;
  logic                  unf_evt;
  logic [PeekWidth-1:0]  top_addr;
  logic [PeekWidth-1:0]  peek_addr;
  logic [CountWidth-1:0] peek_ext;
  logic                  peek_valid;
  logic [DataWidth-1:0]  mem_top;
  logic [DataWidth-1:0]  mem_peek;
  stack_err_t            err_q;

  // Operations in the cycle reset is released are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end

  assign op    = run_q ? decode_op(push, pop) : OP_NONE;
  assign full  = (count == CountWidth'(StackDepth));
  assign empty = (count == '0);

  always_comb begin
    count_nxt = count;
    we        = 1'b0;
    waddr     = '0;
    ovf_evt   = 1'b0;
    unf_evt   = 1'b0;
    case (op)
      OP_PUSH: begin
        if (!full) begin
          we        = 1'b1;
          waddr     = PeekWidth'(count);
          count_nxt = count + 1'b1;
        end else begin
          ovf_evt = 1'b1;
        end
      end
      OP_POP: begin
        if (!empty) count_nxt = count - 1'b1;
        else        unf_evt   = 1'b1;
      end
      OP_REPLACE: begin
        we = 1'b1;
        if (empty) begin
          waddr     = '0;
          count_nxt = CountWidth'(1);
        end else begin
          waddr = PeekWidth'(count - 1'b1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count <= '0;
    else          count <= count_nxt;
  end

  lifo_stack_mem #(
    .StackDepth(StackDepth),
    .DataWidth (DataWidth),
    .AddrWidth (PeekWidth)
  ) u_mem (
    .clk      (clk),
    .we       (we),
    .waddr    (waddr),
    .wdata    (data_in),
    .top_addr (top_addr),
    .top_data (mem_top),
    .peek_addr(peek_addr),
    .peek_data(mem_peek)
  );

  // Out-of-range peeks are steered to slot 0 and masked rather than read past the top.
  assign peek_ext   = CountWidth'(peek_depth);
  assign peek_valid = (peek_ext < count);
  assign top_addr   = empty ? '0 : PeekWidth'(count - 1'b1);
  assign peek_addr  = peek_valid ? PeekWidth'(count - 1'b1 - peek_ext) : '0;
  assign data_out   = empty ? '0 : mem_top;
  assign peek_data  = peek_valid ? mem_peek : '0;

`ifdef LIFO_STACK_ERR_EN
  // A new event beats err_clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= '0;
    end else begin
      if (ovf_evt)        err_q.overflow  <= 1'b1;
      else if (err_clear) err_q.overflow  <= 1'b0;
      if (unf_evt)        err_q.underflow <= 1'b1;
      else if (err_clear) err_q.underflow <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset_n && ovf_evt) $error("lifo_stack: push while full");
    if (reset_n && unf_evt) $error("lifo_stack: pop while empty");
  end
`endif
`else
  logic unused_err;
  assign err_q      = '0;
  assign unused_err = ^{err_clear, ovf_evt, unf_evt};
`endif

  assign overflow  = err_q.overflow;
  assign underflow = err_q.underflow;

endmodule
